vgafb_fetch_sched: RTL and testbench
====================================

VGAFB_FETCH_SCHED -- requirements
Module: vgafb_fetch_sched

Interface
REQ-001 Parameter fml_depth, default 26, FML byte-address width.
REQ-002 Parameter fifo_depth_log2, default 6, pixel FIFO depth is 2^fifo_depth_log2 64-bit words.
REQ-003 The block SHALL have one clock, sys_clk; reset is synchronous and active-high, sys_rst.
REQ-004 sys_clk  in  1  system clock.
REQ-005 sys_rst  in  1  synchronous active-high reset.
REQ-006 vga_rst  in  1  fetch disable: 1 holds or returns the block to IDLE.
REQ-007 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-008 baseaddress  in  fml_depth  framebuffer start byte address, 32-byte aligned.
REQ-009 baseaddress_ack  out  1  one-cycle pulse: baseaddress latched for this frame.
REQ-010 nbursts  in  18  bursts per frame.
REQ-011 fifo_level  in  fifo_depth_log2+1  words currently held in the pixel FIFO.
REQ-012 fml_adr  out  fml_depth  burst byte address.
REQ-013 fml_stb  out  1  burst request.
REQ-014 fml_ack  in  1  burst accepted.
REQ-015 fifo_we  out  1  write strobe: FML read data beat valid, store into FIFO.
REQ-016 frame_late  out  1  one-cycle pulse: frame_start arrived before the frame fetch completed.

Function
REQ-017 States: IDLE, WAIT_FRAME, CHECK, REQ, DATA; one burst outstanding at most.
REQ-018 IDLE: fml_stb=0, fifo_we=0; go to WAIT_FRAME when vga_rst=0.
REQ-019 WAIT_FRAME + frame_start: latch baseaddress into addr_cur, load remaining=nbursts, pulse baseaddress_ack that cycle, go to CHECK.
REQ-020 CHECK: if remaining=0 go to WAIT_FRAME; else if fifo_level <= 2^fifo_depth_log2 - 4 go to REQ; else stay.
REQ-021 REQ: fml_stb=1, fml_adr=addr_cur; stay until fml_ack=1; fml_stb and fml_adr SHALL stay stable until ack.
REQ-022 In the fml_ack cycle go to DATA; addr_cur += 32 modulo 2^fml_depth; remaining -= 1.
REQ-023 DATA: fifo_we=1 on exactly the 4 cycles following the fml_ack cycle; then go to CHECK.
REQ-024 fml_adr low 5 bits SHALL always be 0; baseaddress low 5 bits are ignored.
REQ-025 nbursts=0: baseaddress_ack still pulses; no fml_stb; return to WAIT_FRAME after CHECK.
REQ-026 frame_start in CHECK, REQ or DATA: pulse frame_late next cycle; an in-progress request or burst completes (REQ waits for ack, DATA delivers 4 beats); then restart per REQ-019 with fresh latch, skipping the rest of the old frame.
REQ-027 frame_start in IDLE is ignored, with no frame_late.
REQ-028 vga_rst=1 in WAIT_FRAME or CHECK: go to IDLE next cycle.
REQ-029 vga_rst=1 in REQ: keep fml_stb until ack, drain 4 beats, then IDLE; never drop fml_stb before ack.
REQ-030 vga_rst=1 in DATA: finish remaining beats, then IDLE.
REQ-031 frame_start and vga_rst=1 on the same cycle: vga_rst wins; no latch, no baseaddress_ack.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 sys_rst SHALL override everything, including mid-burst, and abandon the burst.
REQ-034 Reset values: state IDLE, fml_stb=0, fml_adr=0, fifo_we=0, baseaddress_ack=0, frame_late=0, addr_cur=0, remaining=0.

Verification
REQ-035 baseaddress=0x100000, nbursts=3, fifo_level=0, ack 2 cycles after stb -> addresses 0x100000, 0x100020, 0x100040; 12 fifo_we beats; one baseaddress_ack.
REQ-036 fifo_level=61 (depth 64) -> no fml_stb; drop to 60 -> fml_stb next-but-one cycle.
REQ-037 baseaddress=0x3FFFFE0, nbursts=2 -> addresses 0x3FFFFE0, then 0x0000000.
REQ-038 nbursts=0, frame_start -> baseaddress_ack pulse, no fml_stb, back in WAIT_FRAME.
REQ-039 vga_rst=1 while fml_stb waiting for ack -> stb held; ack -> 4 beats -> IDLE; no further stb.
REQ-040 frame_start mid-frame (nbursts=10, after burst 2) -> frame_late pulse; current burst completes; next fml_adr is the new baseaddress.

Source files
------------

// File: rtl/vgafb_fetch_sched.sv
// Frame fetch scheduler for the VGA framebuffer.
// Walks the framebuffer in 32-byte FML bursts once per frame, issuing a burst
// whenever the pixel FIFO has room for four more 64-bit words.
module vgafb_fetch_sched #(
  parameter int fml_depth       = 26,
  parameter int fifo_depth_log2 = 6
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       vga_rst,
  input  logic                       frame_start,
  input  logic [fml_depth-1:0]       baseaddress,
  output logic                       baseaddress_ack,
  input  logic [17:0]                nbursts,
  input  logic [fifo_depth_log2:0]   fifo_level,
  output logic [fml_depth-1:0]       fml_adr,
  output logic                       fml_stb,
  input  logic                       fml_ack,
  output logic                       fifo_we,
  output logic                       frame_late
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_CHECK,
    S_REQ,
    S_DATA
  } state_t;

  // A burst is only requested when the FIFO can absorb all four beats.
  localparam logic [fifo_depth_log2:0] LEVEL_MAX =
    (fifo_depth_log2+1)'((1 << fifo_depth_log2) - 4);

  state_t                 state_q;
  logic [fml_depth-1:0]   addr_cur_q;
  logic [17:0]            remaining_q;
  logic [1:0]             beats_q;      // beats still to deliver after the current one
  logic                   restart_q;    // new frame arrived while a burst was in flight
  logic                   stop_q;       // fetch disabled while a burst was in flight
  logic                   fml_stb_q;
  logic [fml_depth-1:0]   fml_adr_q;
  logic                   fifo_we_q;
  logic                   baseaddress_ack_q;
  logic                   frame_late_q;

  // Burst addresses are 32-byte aligned; the low five address bits are dropped.
  logic [fml_depth-1:0] base_aligned;
  logic [fml_depth-1:0] addr_inc;
  assign base_aligned = baseaddress & ~fml_depth'(31);
  assign addr_inc     = addr_cur_q + fml_depth'(32);

  assign fml_stb         = fml_stb_q;
  assign fml_adr         = fml_adr_q;
  assign fifo_we         = fifo_we_q;
  assign baseaddress_ack = baseaddress_ack_q;
  assign frame_late      = frame_late_q;

  // Fetch sequencer: frame bookkeeping, burst handshake and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // NOTE: every register here is state, so all assignments are non-blocking
      // to keep each read seeing the value from before this clock edge.
      state_q           <= S_IDLE;
      addr_cur_q        <= '0;
      remaining_q       <= '0;
      beats_q           <= '0;
      restart_q         <= 1'b0;
      stop_q            <= 1'b0;
      fml_stb_q         <= 1'b0;
      fml_adr_q         <= '0;
      fifo_we_q         <= 1'b0;
      baseaddress_ack_q <= 1'b0;
      frame_late_q      <= 1'b0;
    end else begin
      baseaddress_ack_q <= 1'b0;
      frame_late_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (!vga_rst) state_q <= S_WAIT_FRAME;
        end

        S_WAIT_FRAME: begin
          if (vga_rst) begin
            state_q <= S_IDLE;
          end else if (frame_start) begin
            addr_cur_q        <= base_aligned;
            remaining_q       <= nbursts;
            baseaddress_ack_q <= 1'b1;
            state_q           <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (vga_rst) begin
            state_q <= S_IDLE;
          end else if (frame_start) begin
            // Nothing in flight: abandon the old frame and restart at once.
            frame_late_q      <= 1'b1;
            addr_cur_q        <= base_aligned;
            remaining_q       <= nbursts;
            baseaddress_ack_q <= 1'b1;
          end else if (remaining_q == '0) begin
            state_q <= S_WAIT_FRAME;
          end else if (fifo_level <= LEVEL_MAX) begin
            fml_stb_q <= 1'b1;
            fml_adr_q <= addr_cur_q;
            state_q   <= S_REQ;
          end
        end

        S_REQ: begin
          // The request is never withdrawn; disable/restart only take effect
          // once the burst has been fully delivered.
          if (vga_rst) begin
            stop_q <= 1'b1;
          end else if (frame_start && !stop_q) begin
            frame_late_q <= 1'b1;
            restart_q    <= 1'b1;
          end
          if (fml_ack) begin
            fml_stb_q   <= 1'b0;
            fifo_we_q   <= 1'b1;
            beats_q     <= 2'd3;
            addr_cur_q  <= addr_inc;
            remaining_q <= remaining_q - 18'd1;
            state_q     <= S_DATA;
          end
        end

        S_DATA: begin
          if (beats_q != 2'd0) begin
            beats_q <= beats_q - 2'd1;
            if (vga_rst) begin
              stop_q <= 1'b1;
            end else if (frame_start && !stop_q) begin
              frame_late_q <= 1'b1;
              restart_q    <= 1'b1;
            end
          end else begin
            fifo_we_q <= 1'b0;
            restart_q <= 1'b0;
            stop_q    <= 1'b0;
            if (vga_rst || stop_q) begin
              state_q <= S_IDLE;
            end else if (restart_q || frame_start) begin
              if (frame_start) frame_late_q <= 1'b1;
              addr_cur_q        <= base_aligned;
              remaining_q       <= nbursts;
              baseaddress_ack_q <= 1'b1;
              state_q           <= S_CHECK;
            end else begin
              state_q <= S_CHECK;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vgafb_fetch_sched.sv
// Self-checking bench for vgafb_fetch_sched: directed scenarios plus random
// frames, checked against a frame-level model (base + 32*k, burst budget,
// four beats per accepted burst, pulse counts).
module tb_vgafb_fetch_sched;
  localparam int AW = 26;
  localparam int LW = 7;

  logic          sys_clk = 1'b0;
  logic          sys_rst, vga_rst, frame_start;
  logic [AW-1:0] baseaddress;
  logic          baseaddress_ack;
  logic [17:0]   nbursts;
  logic [LW-1:0] fifo_level;
  logic [AW-1:0] fml_adr;
  logic          fml_stb;
  logic          fml_ack = 1'b0;
  logic          fifo_we, frame_late;

  vgafb_fetch_sched #(.fml_depth(AW), .fifo_depth_log2(6)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .vga_rst(vga_rst),
    .frame_start(frame_start), .baseaddress(baseaddress),
    .baseaddress_ack(baseaddress_ack), .nbursts(nbursts),
    .fifo_level(fifo_level), .fml_adr(fml_adr), .fml_stb(fml_stb),
    .fml_ack(fml_ack), .fifo_we(fifo_we), .frame_late(frame_late)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame-level reference model and memory responder state.
  bit            m_en = 1'b0;
  int            m_rem = 0;
  logic [AW-1:0] m_next = '0;
  bit            inflight = 1'b0;
  int            beats_left = 0;
  int            exp_ack = 0, exp_late = 0;
  int            n_ack_obs = 0, n_late_obs = 0, n_rise = 0, n_we = 0, bursts_done = 0;
  int            ack_delay = 2, wait_cnt = 0;
  bit            stb_prev = 1'b0, ack_prev = 1'b0;
  logic [AW-1:0] adr_prev = '0;
  logic [LW-1:0] lvl_prev = '0;

  // Monitor, model update and FML responder, all away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      m_en = 1'b0; m_rem = 0; inflight = 1'b0; beats_left = 0;
      wait_cnt = 0; stb_prev = 1'b0; ack_prev = 1'b0; fml_ack = 1'b0;
    end else begin
      if (stb_prev && ack_prev) begin
        inflight = 1'b0;
        beats_left = 4;
        bursts_done++;
      end
      check("fifo_we", fifo_we, beats_left > 0);
      if (fifo_we) n_we++;
      if (beats_left > 0) beats_left--;

      if (stb_prev && !ack_prev) begin
        check("stb_held", fml_stb, 1'b1);
        check("adr_stable", fml_adr, adr_prev);
      end else if (fml_stb) begin
        n_rise++;
        check("stb_allowed", m_en && m_rem > 0, 1'b1);
        check("fifo_room", lvl_prev <= LW'(60), 1'b1);
        check("fml_adr", fml_adr, m_next);
        m_next = m_next + AW'(32);
        m_rem--;
        inflight = 1'b1;
      end

      if (baseaddress_ack) n_ack_obs++;
      if (frame_late) n_late_obs++;

      if (fml_stb) begin
        wait_cnt++;
        fml_ack = (wait_cnt >= ack_delay);
      end else begin
        wait_cnt = 0;
        fml_ack = 1'b0;
      end

      // Inputs visible now are what the next active edge will sample.
      if (vga_rst) begin
        m_en = 1'b0;
        m_rem = 0;
      end else begin
        if (frame_start && m_en) begin
          if (m_rem > 0 || inflight || beats_left > 0) exp_late++;
          exp_ack++;
          m_next = baseaddress & ~AW'(31);
          m_rem = int'(nbursts);
        end
        m_en = 1'b1;
      end
      stb_prev = fml_stb;
      ack_prev = fml_ack;
      adr_prev = fml_adr;
      lvl_prev = fifo_level;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int nb);
    baseaddress = base;
    nbursts = 18'(nb);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int limit);
    bit done;
    done = 1'b0;
    tick(2);
    for (int i = 0; i < limit && !done; i++) begin
      if (m_rem == 0 && !inflight && beats_left == 0) done = 1'b1;
      else tick(1);
    end
    check({"quiet_", tag}, done, 1'b1);
    tick(4);
  endtask

  task automatic wait_bursts(input string tag, input int target);
    for (int i = 0; i < 300 && bursts_done < target; i++) tick(1);
    check(tag, bursts_done >= target, 1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ack"}, n_ack_obs, exp_ack);
    check({tag, "_late"}, n_late_obs, exp_late);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_stb"}, fml_stb, 1'b0);
    check({tag, "_adr"}, fml_adr, '0);
    check({tag, "_we"}, fifo_we, 1'b0);
    check({tag, "_back"}, baseaddress_ack, 1'b0);
    check({tag, "_late"}, frame_late, 1'b0);
  endtask

  initial begin
    int r0, w0, l0, d0, nb;
    logic [AW-1:0] base;

    sys_rst = 1'b1; vga_rst = 1'b1; frame_start = 1'b0;
    baseaddress = '0; nbursts = '0; fifo_level = '0;
    tick(3);
    sys_rst = 1'b0;
    tick(1);
    check_outputs_idle("reset");

    // Disabled block: frame_start together with vga_rst, then in IDLE.
    start_frame(AW'(32'h0010000), 2);
    tick(4);
    check_counts("idle_fs");
    check("idle_no_stb", n_rise, 0);

    vga_rst = 1'b0;
    tick(3);

    // Three bursts from 0x100000, ack two cycles after request.
    r0 = n_rise; w0 = n_we;
    start_frame(AW'(32'h0100000), 3);
    wait_quiet("basic", 200);
    check("basic_bursts", n_rise - r0, 3);
    check("basic_beats", n_we - w0, 12);
    check_counts("basic");

    // Address wrap at the top of the FML space.
    r0 = n_rise;
    start_frame(AW'(32'h3FFFFE0), 2);
    wait_quiet("wrap", 200);
    check("wrap_bursts", n_rise - r0, 2);
    check_counts("wrap");

    // Empty frame: acknowledged, no traffic.
    r0 = n_rise;
    start_frame(AW'(32'h0200000), 0);
    wait_quiet("empty", 20);
    check("empty_bursts", n_rise - r0, 0);
    check_counts("empty");

    // FIFO threshold: 61 words blocks, 60 words releases.
    fifo_level = LW'(61);
    r0 = n_rise;
    start_frame(AW'(32'h0200040), 1);
    tick(20);
    check("fifo61_no_stb", n_rise - r0, 0);
    fifo_level = LW'(60);
    for (int i = 0; i < 4 && n_rise == r0; i++) tick(1);
    check("fifo60_stb", n_rise - r0, 1);
    wait_quiet("fifo", 100);
    fifo_level = '0;
    check_counts("fifo");

    // Frame restart after the second of ten bursts.
    l0 = n_late_obs; d0 = bursts_done; r0 = n_rise;
    start_frame(AW'(32'h0040000), 10);
    wait_bursts("late_reach2", d0 + 2);
    start_frame(AW'(32'h0080000), 2);
    wait_quiet("late", 300);
    check("late_pulse", n_late_obs - l0, 1);
    check_counts("late");

    // Fetch disabled while a request waits for its ack.
    ack_delay = 8; r0 = n_rise; w0 = n_we;
    start_frame(AW'(32'h00ABC00), 5);
    for (int i = 0; i < 10 && !fml_stb; i++) tick(1);
    check("dis_stb_seen", fml_stb, 1'b1);
    vga_rst = 1'b1;
    wait_quiet("dis", 100);
    tick(20);
    check("dis_one_burst", n_rise - r0, 1);
    check("dis_beats", n_we - w0, 4);
    check_counts("dis");
    vga_rst = 1'b0; ack_delay = 2;
    tick(3);

    // System reset in the middle of a burst.
    start_frame(AW'(32'h0300000), 4);
    for (int i = 0; i < 30 && beats_left == 0; i++) tick(1);
    check("rst_in_data", beats_left > 0, 1'b1);
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    check_outputs_idle("midrst");
    r0 = n_rise;
    tick(20);
    check("midrst_no_stb", n_rise - r0, 0);
    check_counts("midrst");

    // Random frames, random ack latency, occasional mid-frame restart.
    for (int k = 0; k < 8; k++) begin
      base = AW'($urandom);
      nb = int'($urandom_range(1, 6));
      fifo_level = LW'($urandom_range(0, 60));
      ack_delay = int'($urandom_range(1, 4));
      d0 = bursts_done;
      start_frame(base, nb);
      if (nb >= 4 && $urandom_range(0, 1) == 1) begin
        wait_bursts("rnd_reach", d0 + 1);
        tick(int'($urandom_range(0, 3)));
        if (m_rem >= 3) start_frame(AW'($urandom), int'($urandom_range(1, 3)));
      end
      wait_quiet("rnd", 400);
      check_counts("rnd");
    end

    check_counts("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
